// File: rtl/apb_arbiter_2m.sv
// apb_arbiter_2m: two-master, one-slave APB arbiter.
// Runs one slave transfer at a time. When both masters request at once, the
// master that was not served last wins (round robin). Each master gets its
// responses from registers.
// Optional build macro APB_ARB_TIMEOUT_EN adds a watchdog. It ends an ACCESS
// phase the slave never completes, and reports an error to the owner.
`timescale 1ns/1ps
module apb_arbiter_2m #(
    parameter int PADDR_WL   = 8,
    parameter int PDATA_WL   = 8,
    parameter int TIMEOUT_WL = 4
) (
    input  logic                clk,
    input  logic                reset_b,
    // master 0
    input  logic                m0_psel,
    input  logic                m0_penable,
    input  logic                m0_pwrite,
    input  logic [PADDR_WL-1:0] m0_paddr,
    input  logic [PDATA_WL-1:0] m0_pwdata,
    output logic [PDATA_WL-1:0] m0_prdata,
    output logic                m0_pready,
    output logic                m0_pslverr,
    // master 1
    input  logic                m1_psel,
    input  logic                m1_penable,
    input  logic                m1_pwrite,
    input  logic [PADDR_WL-1:0] m1_paddr,
    input  logic [PDATA_WL-1:0] m1_pwdata,
    output logic [PDATA_WL-1:0] m1_prdata,
    output logic                m1_pready,
    output logic                m1_pslverr,
    // slave
    output logic                s_psel,
    output logic                s_penable,
    output logic                s_pwrite,
    output logic [PADDR_WL-1:0] s_paddr,
    output logic [PDATA_WL-1:0] s_pwdata,
    input  logic [PDATA_WL-1:0] s_prdata,
    input  logic                s_pready,
    input  logic                s_pslverr,
    // current owner, one-hot
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  last_gnt;     // index of the master served last
    logic [1:0]            grant_pick;   // one-hot winner of this IDLE cycle
    logic                  xfer_done;    // ACCESS ends this cycle
    logic                  wd_expire;    // watchdog ends ACCESS this cycle
    logic                  own_pwrite;
    logic [PADDR_WL-1:0]   own_paddr;
    logic [PDATA_WL-1:0]   own_pwdata;
    logic [PDATA_WL-1:0]   rsp_rdata;
    logic                  rsp_err;

    // The arbiter tracks the APB phase itself, so master penable carries no
    // extra information.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    // A zero-width watchdog counter cannot be built.
    if (TIMEOUT_WL < 1) begin : g_bad_timeout_wl
        $error("apb_arbiter_2m: TIMEOUT_WL must be at least 1");
    end

`ifdef APB_ARB_TIMEOUT_EN
    // The watchdog fires on the (2^TIMEOUT_WL-1)-th unanswered ACCESS cycle.
    localparam logic [TIMEOUT_WL-1:0] WD_LAST = TIMEOUT_WL'((2 ** TIMEOUT_WL) - 2);

    logic [TIMEOUT_WL-1:0] wd_cnt;

    // Count ACCESS cycles without s_pready. The count restarts with each new transfer.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wd_cnt <= '0;
        end else if (state_nxt == ST_SETUP) begin
            wd_cnt <= '0;
        end else if ((state == ST_ACCESS) && !s_pready) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // If s_pready arrives in the limit cycle, it wins: expiry needs s_pready low.
    assign wd_expire = (state == ST_ACCESS) && !s_pready && (wd_cnt == WD_LAST);
`else
    assign wd_expire = 1'b0;
`endif

    assign xfer_done = (state == ST_ACCESS) && (s_pready || wd_expire);

    // Round-robin pick among the masters requesting in this cycle.
    always_comb begin
        grant_pick = 2'b00;
        case ({m1_psel, m0_psel})
            2'b01:   grant_pick = 2'b01;
            2'b10:   grant_pick = 2'b10;
            2'b11:   grant_pick = last_gnt ? 2'b01 : 2'b10;
            default: grant_pick = 2'b00;
        endcase
    end

    // State register. Async reset drops s_psel at once, mid-transfer included.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Requests are sampled only in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = (|grant_pick) ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = xfer_done ? ST_RESP : ST_ACCESS;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Latch the owner on a grant. Record it as last served when the response is issued.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            grant    <= 2'b00;
            last_gnt <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: grant <= grant_pick;
                ST_RESP: begin
                    last_gnt <= grant[1];
                    grant    <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    // Select the owner's request fields. Grant stays latched, so the transfer survives the owner dropping psel.
    always_comb begin
        own_pwrite = 1'b0;
        own_paddr  = '0;
        own_pwdata = '0;
        if (grant[0]) begin
            own_pwrite = m0_pwrite;
            own_paddr  = m0_paddr;
            own_pwdata = m0_pwdata;
        end else if (grant[1]) begin
            own_pwrite = m1_pwrite;
            own_paddr  = m1_paddr;
            own_pwdata = m1_pwdata;
        end
    end

    // Slave-side outputs. Address and data are forced to 0 outside an active select.
    always_comb begin
        s_psel    = (state == ST_SETUP) || (state == ST_ACCESS);
        s_penable = (state == ST_ACCESS);
        s_pwrite  = s_psel && own_pwrite;
        s_paddr   = s_psel ? own_paddr : '0;
        s_pwdata  = (s_psel && own_pwrite) ? own_pwdata : '0;
    end

    // Response value. A write returns 0; a watchdog expiry returns 0 with an error.
    always_comb begin
        rsp_rdata = (own_pwrite || wd_expire) ? '0 : s_prdata;
        rsp_err   = s_pslverr || wd_expire;
    end

    // Per-master response registers. pready pulses only in RESP; data holds until the next response.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            m0_prdata  <= '0;
            m0_pslverr <= 1'b0;
            m0_pready  <= 1'b0;
            m1_prdata  <= '0;
            m1_pslverr <= 1'b0;
            m1_pready  <= 1'b0;
        end else begin
            m0_pready <= xfer_done && grant[0];
            m1_pready <= xfer_done && grant[1];
            if (xfer_done && grant[0]) begin
                m0_prdata  <= rsp_rdata;
                m0_pslverr <= rsp_err;
            end
            if (xfer_done && grant[1]) begin
                m1_prdata  <= rsp_rdata;
                m1_pslverr <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_apb_arbiter_2m.sv
// tb_apb_arbiter_2m: self-checking bench for apb_arbiter_2m.
// The bench has two APB master drivers and a slave responder with random wait
// states. A scoreboard queue holds the expected responses for each master.
// A monitor checks arbitration order, slave-bus contents and response latency
// against rules computed from the arbiter's behaviour.
`timescale 1ns/1ps
module tb_apb_arbiter_2m;
    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int TW     = 4;
    localparam int WD_LAT = 2 + (2 ** TW) - 2;  // SETUP to pready when the watchdog fires

    logic          clk = 1'b0;
    logic          reset_b = 1'b0;
    logic          m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
    logic [AW-1:0] m0_paddr = '0;
    logic [DW-1:0] m0_pwdata = '0;
    logic [DW-1:0] m0_prdata;
    logic          m0_pready, m0_pslverr;
    logic          m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
    logic [AW-1:0] m1_paddr = '0;
    logic [DW-1:0] m1_pwdata = '0;
    logic [DW-1:0] m1_prdata;
    logic          m1_pready, m1_pslverr;
    logic          s_psel, s_penable, s_pwrite;
    logic [AW-1:0] s_paddr;
    logic [DW-1:0] s_pwdata;
    logic [DW-1:0] s_prdata = '0;
    logic          s_pready = 1'b0, s_pslverr = 1'b0;
    logic [1:0]    grant;

    apb_arbiter_2m #(.PADDR_WL(AW), .PDATA_WL(DW), .TIMEOUT_WL(TW)) dut (
        .clk(clk), .reset_b(reset_b),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_prdata(m0_prdata),
        .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_prdata(m1_prdata),
        .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr),
        .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t          exp_q0[$];
    rsp_t          exp_q1[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic          cur_wr[2];
    logic [AW-1:0] cur_addr[2];
    logic [DW-1:0] cur_wdata[2];
    int            force_wait = -1;   // -1: random slave wait states
    bit            hang = 1'b0;       // slave never answers
    int            cyc = 0;
    int            wt = 0;            // wait states chosen for the current slave transfer
    int            wc = 0;
    int            last_own = 1;
    bit            pp0 = 1'b0, pp1 = 1'b0;
    int            setup_cyc = 0;
    int            e;
    rsp_t          mr;

    // Slave contents: read data and error are pure functions of the address.
    function automatic logic [DW-1:0] slv_rd(input logic [AW-1:0] a);
        return a ^ 8'h68;
    endfunction

    function automatic logic slv_err(input logic [AW-1:0] a);
        return (a[7:4] == 4'hF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_s_psel"},     32'(s_psel),     32'd0);
        chk({p, "_s_penable"},  32'(s_penable),  32'd0);
        chk({p, "_s_pwrite"},   32'(s_pwrite),   32'd0);
        chk({p, "_s_paddr"},    32'(s_paddr),    32'd0);
        chk({p, "_s_pwdata"},   32'(s_pwdata),   32'd0);
        chk({p, "_grant"},      32'(grant),      32'd0);
        chk({p, "_m0_pready"},  32'(m0_pready),  32'd0);
        chk({p, "_m1_pready"},  32'(m1_pready),  32'd0);
        chk({p, "_m0_prdata"},  32'(m0_prdata),  32'd0);
        chk({p, "_m1_prdata"},  32'(m1_prdata),  32'd0);
        chk({p, "_m0_pslverr"}, 32'(m0_pslverr), 32'd0);
        chk({p, "_m1_pslverr"}, 32'(m1_pslverr), 32'd0);
    endtask

    // One APB transfer from master m. Entered and left just after a rising edge.
    task automatic master_xfer(input int m, input logic wr, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
        rsp_t r;
        bit   got;
        got     = 1'b0;
        r.rdata = wr ? 8'h00 : slv_rd(a);
        r.err   = slv_err(a);
`ifdef APB_ARB_TIMEOUT_EN
        if (hang) begin
            r.rdata = 8'h00;
            r.err   = 1'b1;
        end
`endif
        cur_wr[m]    = wr;
        cur_addr[m]  = a;
        cur_wdata[m] = d;
        if (m == 0) begin
            exp_q0.push_back(r);
            m0_psel = 1'b1; m0_penable = 1'b0; m0_pwrite = wr; m0_paddr = a; m0_pwdata = d;
        end else begin
            exp_q1.push_back(r);
            m1_psel = 1'b1; m1_penable = 1'b0; m1_pwrite = wr; m1_paddr = a; m1_pwdata = d;
        end
        @(posedge clk); #1;
        if (m == 0) m0_penable = 1'b1; else m1_penable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_pready) || (m == 1 && m1_pready)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk((m == 0) ? "m0_pready_timeout" : "m1_pready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (m == 0) begin m0_psel = 1'b0; m0_penable = 1'b0; end
        else        begin m1_psel = 1'b0; m1_penable = 1'b0; end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Slave responder. A wait count is picked at SETUP; read data is garbage except on pready.
    initial begin
        forever begin
            @(negedge clk);
            s_pready  = 1'b0;
            s_prdata  = 8'($urandom);
            s_pslverr = 1'($urandom);
            if (!reset_b) continue;
            if (s_psel && !s_penable) begin
                wt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                wc = 0;
            end else if (s_psel && s_penable && !hang) begin
                if (wc >= wt) begin
                    s_pready  = 1'b1;
                    s_prdata  = slv_rd(s_paddr);
                    s_pslverr = slv_err(s_paddr);
                end else begin
                    wc++;
                end
            end
        end
    end

    // Monitor and scoreboard. Checks arbitration, bus contents, responses and latency.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_b) begin
                last_own = 1;
                pp0 = 1'b0;
                pp1 = 1'b0;
                continue;
            end
            if (!s_psel) begin
                chk("slave_bus_idle", 32'({s_penable, s_pwrite, s_paddr, s_pwdata}), 32'd0);
            end else if (!s_penable) begin
                if (pp0 && pp1)  e = 1 - last_own;
                else if (pp0)    e = 0;
                else if (pp1)    e = 1;
                else             e = -1;
                if (e < 0) begin
                    chk("setup_without_request", 32'd1, 32'd0);
                end else begin
                    chk("grant_at_setup", 32'(grant), (e == 0) ? 32'd1 : 32'd2);
                    chk("s_paddr",  32'(s_paddr),  32'(cur_addr[e]));
                    chk("s_pwrite", 32'(s_pwrite), 32'(cur_wr[e]));
                    chk("s_pwdata", 32'(s_pwdata), cur_wr[e] ? 32'(cur_wdata[e]) : 32'd0);
                    last_own = e;
                end
                setup_cyc = cyc;
            end else begin
                chk("grant_in_access", 32'(grant), (last_own == 0) ? 32'd1 : 32'd2);
            end
            chk("both_pready", 32'(m0_pready & m1_pready), 32'd0);
            if (m0_pready) begin
                if (exp_q0.size() == 0) begin
                    chk("m0_unexpected_pready", 32'd1, 32'd0);
                end else begin
                    mr = exp_q0.pop_front();
                    chk("m0_prdata",  32'(m0_prdata),  32'(mr.rdata));
                    chk("m0_pslverr", 32'(m0_pslverr), 32'(mr.err));
                    chk("m0_latency", 32'(cyc - setup_cyc), hang ? 32'(WD_LAT) : 32'(2 + wt));
                    chk("m0_grant_in_resp", 32'(grant), 32'd1);
                end
            end
            if (m1_pready) begin
                if (exp_q1.size() == 0) begin
                    chk("m1_unexpected_pready", 32'd1, 32'd0);
                end else begin
                    mr = exp_q1.pop_front();
                    chk("m1_prdata",  32'(m1_prdata),  32'(mr.rdata));
                    chk("m1_pslverr", 32'(m1_pslverr), 32'(mr.err));
                    chk("m1_latency", 32'(cyc - setup_cyc), hang ? 32'(WD_LAT) : 32'(2 + wt));
                    chk("m1_grant_in_resp", 32'(grant), 32'd2);
                end
            end
            pp0 = m0_psel;
            pp1 = m1_psel;
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running, expected finished");
        $fatal(1, "time limit");
    end

    // Stimulus sequence.
    initial begin
        reset_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_b = 1'b1;
        idle_gap(1);

        // single write, no slave wait states
        force_wait = 0;
        master_xfer(0, 1'b1, 8'h12, 8'hA5);
        chk("m0_write_rdata", 32'(m0_prdata), 32'd0);

        // single read, two slave wait states
        force_wait = 2;
        master_xfer(1, 1'b0, 8'h34, 8'h00);
        chk("m1_read_5c", 32'(m1_prdata), 32'h5C);
        chk("m0_prdata_held", 32'(m0_prdata), 32'd0);

        // repeated simultaneous requests must alternate
        force_wait = -1;
        for (int k = 0; k < 4; k++) begin
            fork
                master_xfer(0, 1'($urandom), 8'($urandom), 8'($urandom));
                master_xfer(1, 1'($urandom), 8'($urandom), 8'($urandom));
            join
        end

        // late request while master 0 is already in ACCESS
        force_wait = 3;
        fork
            master_xfer(0, 1'b0, 8'h56, 8'h00);
            begin
                idle_gap(3);
                master_xfer(1, 1'b1, 8'h78, 8'h9C);
            end
        join

        // random mixed traffic
        force_wait = -1;
        fork
            for (int i = 0; i < 40; i++) begin
                master_xfer(0, 1'($urandom), 8'($urandom), 8'($urandom));
                idle_gap(int'($urandom_range(0, 2)));
            end
            for (int j = 0; j < 40; j++) begin
                master_xfer(1, 1'($urandom), 8'($urandom), 8'($urandom));
                idle_gap(int'($urandom_range(0, 2)));
            end
        join

`ifdef APB_ARB_TIMEOUT_EN
        // slave never answers; then a normal transfer
        hang = 1'b1;
        master_xfer(0, 1'b0, 8'h21, 8'h00);
        chk("timeout_err", 32'(m0_pslverr), 32'd1);
        hang = 1'b0;
        master_xfer(0, 1'b0, 8'h22, 8'h00);
        chk("after_timeout_rdata", 32'(m0_prdata), 32'(8'h22 ^ 8'h68));
`endif

        // reset asserted while the slave holds ACCESS
        hang = 1'b1;
        cur_wr[0] = 1'b0; cur_addr[0] = 8'h40; cur_wdata[0] = 8'h00;
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 8'h40; m0_pwdata = 8'h00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_penable) break;
        end
        chk("reached_access", 32'(s_penable), 32'd1);
        @(negedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        chk_all_zero("midrst");
        m0_psel = 1'b0;
        hang = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b1;
        idle_gap(1);
        fork
            master_xfer(0, 1'b0, 8'h0A, 8'h00);
            master_xfer(1, 1'b0, 8'h0B, 8'h00);
        join
        chk("post_reset_m0_rdata", 32'(m0_prdata), 32'(8'h0A ^ 8'h68));
        chk("post_reset_m1_rdata", 32'(m1_prdata), 32'(8'h0B ^ 8'h68));

        idle_gap(3);
        chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_arbiter_2m.md
# apb_arbiter_2m

Two-master, one-slave APB arbiter. It shares a single APB register/peripheral bus between the I2C slave bridge (master 0) and a second bus master such as the scan/SPI bridge (master 1). It runs one transfer at a time with round-robin priority, and returns registered responses to the granted master. An optional watchdog terminates transfers the slave never completes.

## Interface
Parameters:
- PADDR_WL, 8, address width of all three ports
- PDATA_WL, 8, data width of all three ports
- TIMEOUT_WL, 4, width of the watchdog counter; limit is 2^TIMEOUT_WL-1 wait cycles

Ports:
- clk  in  1  clock
- reset_b  in  1  reset; asynchronous, active-low
- mN_psel, mN_penable, mN_pwrite  in  1  master N (N=0,1) APB controls
- mN_paddr  in  PADDR_WL  master N address
- mN_pwdata  in  PDATA_WL  master N write data
- mN_prdata  out  PDATA_WL  master N read data, registered
- mN_pready  out  1  master N transfer-complete pulse, registered
- mN_pslverr  out  1  master N error, valid with mN_pready
- s_psel, s_penable, s_pwrite  out  1  slave-side APB controls
- s_paddr  out  PADDR_WL  slave address; 0 when s_psel=0
- s_pwdata  out  PDATA_WL  slave write data; 0 unless s_psel and s_pwrite
- s_prdata  in  PDATA_WL  slave read data
- s_pready, s_pslverr  in  1  slave completion and error
- grant  out  2  one-hot current owner; 00 in IDLE

## Operation
- Masters follow APB. Each master holds psel, pwrite, paddr and pwdata stable from its setup phase until it samples its own pready high. Wait states are imposed by holding mN_pready low.
- State register has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - A request is mN_psel=1.
  - If one master requests, grant it.
  - If both request, grant the master not in last_gnt.
  - On a grant, latch the owner into grant and go to SETUP.
- SETUP:
  - s_psel=1, s_penable=0.
  - s_pwrite, s_paddr and s_pwdata are muxed combinationally from the owner.
  - Go to ACCESS.
- ACCESS:
  - s_psel=1, s_penable=1.
  - On s_pready=1, capture s_prdata (reads only; writes capture 0) and s_pslverr into the owner's response registers, then go to RESP.
- RESP:
  - The owner's mN_pready=1 for exactly one cycle. mN_prdata and mN_pslverr hold the captured values.
  - Update last_gnt to the owner, clear grant, go to IDLE.
- mN_prdata holds its last value until the next response to that master.
- The non-owner's pready is always 0.
- Round-robin state last_gnt resets to 1, so master 0 wins the first contention.
- If the owner drops psel before RESP, the slave transfer still completes and the RESP pulse is still issued.
- Requests are only sampled in IDLE. A request raised during a transfer waits, and its master sees pready held low.

## Timing
- Uncontended transfer: master psel seen in cycle 0 (IDLE) → s_psel in cycle 1 → s_penable in cycle 2.
- With zero slave wait states, mN_pready is high in cycle 3. Each slave wait cycle adds one cycle.
- Back-to-back from one master: a new psel in the cycle after RESP is arbitrated in that IDLE cycle. Slave-side spacing is 1 idle cycle between transfers.
- Under sustained contention, grants alternate strictly: 0, 1, 0, 1 …
- Reset values:
  - All outputs 0.
  - State IDLE, last_gnt=1, watchdog counter 0.
- Reset mid-transfer:
  - s_psel drops asynchronously.
  - No pready is issued for the aborted transfer.

## Configuration
- APB_ARB_TIMEOUT_EN defined:
  - The watchdog counts ACCESS cycles with s_pready=0.
  - When the count reaches 2^TIMEOUT_WL-1 with s_pready still low, the arbiter deasserts s_psel/s_penable and goes to RESP with mN_pslverr=1 and mN_prdata=0.
  - The counter clears on entry to SETUP.
  - s_pready arriving in the limit cycle wins, giving a normal completion.
- Macro undefined:
  - No counter; ACCESS waits indefinitely.
  - mN_pslverr reflects s_pslverr only.

## Test plan
- Single write: m0 writes 0xA5 to 0x12, slave pready immediate → s_paddr=0x12 and s_pwdata=0xA5 in cycles 1–2; m0_pready pulses in cycle 3; m1_pready stays 0.
- Single read with wait states: m1 reads 0x34, slave returns 0x5C after 2 wait cycles → m1_prdata=0x5C; m1_pready in cycle 5; grant=10 during the transfer.
- Contention: m0 and m1 raise psel in the same cycle after reset → m0 served first, then m1. Repeat: m0 and m1 alternate, never the same master twice while both request.
- Late request: m1 raises psel while m0 is in ACCESS → m1 starts SETUP only after m0's RESP and one IDLE cycle; m1_pready stays 0 until then.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_WL=4): slave never asserts pready → after 15 ACCESS cycles, m0_pslverr=1 and m0_prdata=0; next transfer proceeds normally.
- Reset mid-ACCESS: assert reset_b low → all outputs 0 immediately; after release, the first contention is granted to m0.
